multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Sequencing controller for the team's multi-cycle RV32I datapath.
- Replaces the single-cycle combinational control unit.
- Steps each instruction through IF/ID/EX/MEM/WB over a shared ALU and a single unified instruction/data memory.
- Generates every datapath enable and mux select, handshakes with memory via mem_ready, and detects the halting ecall.

Parameters:
HALT_X17_VAL, 32'd10, value of x17 that makes ecall halt the core
STATE_W, 3, width of state encoding

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
opcode  input  7  instruction[6:0] from instruction register
bcond  input  1  ALU branch-condition result
x17_val  input  32  current register x17 contents
mem_ready  input  1  memory completed current read/write this cycle
pc_write  output  1  load PC at next edge
ir_write  output  1  load IR and old_pc at next edge
i_or_d  output  1  memory address: 0=PC, 1=ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
reg_write  output  1  register file write enable
alu_src_a  output  2  00=PC, 01=old_pc, 10=rs1
alu_src_b  output  2  00=rs2, 01=const 4, 10=imm
alu_op_class  output  2  00=ADD, 01=by funct3/funct7, 10=branch compare
pc_source  output  2  00=ALU result, 01=ALUOut, 10=ALU result & ~1
wb_sel  output  2  rd data: 00=ALUOut, 01=MDR, 10=PC
is_halted  output  1  sticky halt indication
state  output  STATE_W  current state (debug)

Behaviour:
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5.
- Opcodes:
  - R=0110011, I=0010011, LOAD=0000011, STORE=0100011
  - BRANCH=1100011, JAL=1101111, JALR=1100111, ECALL=1110011
- Reset low → state=IF, is_halted=0. Reset is asynchronous and overrides any state, including mid-MEM.
- Outputs not listed for a state are 0; all selects default 00.
- IF:
  - mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_op_class=00.
  - pc_write=ir_write=mem_ready (PC←PC+4, IR and old_pc latched together).
  - Stay in IF while mem_ready=0; go to ID on mem_ready.
- ID:
  - alu_src_a=01, alu_src_b=10, ADD: ALUOut←old_pc+imm (branch/JAL target).
  - ECALL: x17_val==HALT_X17_VAL → HALT, else → IF.
  - Undefined opcode → IF (acts as nop; PC already advanced).
  - All other opcodes → EX.
- EX:
  - R: src_a=10, src_b=00, class 01 → WB.
  - I: src_a=10, src_b=10, class 01 → WB.
  - LOAD/STORE: src_a=10, src_b=10, class 00 → MEM.
  - BRANCH: src_a=10, src_b=00, class 10; pc_write=bcond, pc_source=01 → IF.
  - JAL: reg_write=1, wb_sel=10, pc_write=1, pc_source=01 → IF.
  - JALR: src_a=10, src_b=10, class 00; reg_write=1, wb_sel=10, pc_write=1, pc_source=10 → IF.
  - rd==rs1 on JALR is legal: rs1 is read combinationally before the edge.
- MEM:
  - i_or_d=1.
  - LOAD: mem_read=1, hold until mem_ready, then → WB (MDR latched by datapath).
  - STORE: mem_write=1, hold until mem_ready, then → IF.
  - mem_read/mem_write stay asserted and stable every stall cycle.
- WB: reg_write=1; wb_sel=01 for LOAD, 00 otherwise → IF.
- HALT:
  - is_halted=1, all enables 0, no exit except reset.
  - is_halted goes high the cycle after ID sees a halting ecall.
- Latency (mem_ready always 1): R/I/LOAD-store-free ops 4 cycles, LOAD 5, STORE 4, BRANCH/JAL/JALR 3, non-halting ECALL 2.
- Every mem_ready=0 cycle in IF or MEM adds exactly one cycle.
- mem_ready is ignored in ID/EX/WB/HALT.
- Never assert pc_write in two consecutive cycles except IF→ID→… sequences per the table above.
- mem_read and mem_write are never asserted together.

Test Plan:
- ADD (opcode 0110011), mem_ready=1 → state sequence 0,1,2,4,0; reg_write only in WB; pc_write only in IF; 4 cycles.
- LOAD with mem_ready low 2 cycles in IF and 3 in MEM → 10 cycles total; mem_read held steady; wb_sel=01 in WB.
- BRANCH with bcond=1, then bcond=0 → pc_write=1 with pc_source=01 in EX, then pc_write=0; both return to IF after 3 cycles.
- JALR → EX shows reg_write=1, wb_sel=10, pc_write=1, pc_source=10, alu_src_a=10, alu_src_b=10.
- ECALL with x17_val=5 → returns to IF, is_halted=0; ECALL with x17_val=10 → HALT, is_halted=1 held 20 cycles despite mem_ready toggling.
- reset driven low asynchronously mid-MEM of a STORE (mem_write=1) → immediately state=0 and mem_write=0 before next clk edge; resumes in IF after reset rises.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencing controller: walks each instruction through IF/ID/EX/MEM/WB,
// drives all datapath enables and mux selects, and parks in HALT on the halting ecall.
module multicycle_control_fsm #(
    parameter logic [31:0] HALT_X17_VAL = 32'd10,
    parameter int unsigned STATE_W      = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic               bcond,
    input  logic [31:0]        x17_val,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ir_write,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg_write,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op_class,
    output logic [1:0]         pc_source,
    output logic [1:0]         wb_sel,
    output logic               is_halted,
    output logic [STATE_W-1:0] state
);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpEcall  = 7'b1110011;

    typedef enum logic [2:0] {
        StIf   = 3'd0,
        StId   = 3'd1,
        StEx   = 3'd2,
        StMem  = 3'd3,
        StWb   = 3'd4,
        StHalt = 3'd5
    } state_e;

    state_e state_q, state_d;
    logic   op_known;

    assign op_known = (opcode == OpR) || (opcode == OpI) || (opcode == OpLoad) ||
                      (opcode == OpStore) || (opcode == OpBranch) || (opcode == OpJal) ||
                      (opcode == OpJalr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIf;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        i_or_d       = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        alu_op_class = 2'b00;
        pc_source    = 2'b00;
        wb_sel       = 2'b00;
        case (state_q)
            StIf: begin
                // PC+4 computed on the ALU while the instruction is fetched
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
                if (mem_ready) state_d = StId;
            end
            StId: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                if (opcode == OpEcall) begin
                    state_d = (x17_val == HALT_X17_VAL) ? StHalt : StIf;
                end else if (op_known) begin
                    state_d = StEx;
                end else begin
                    state_d = StIf;
                end
            end
            StEx: begin
                state_d = StIf;
                case (opcode)
                    OpR: begin
                        alu_src_a    = 2'b10;
                        alu_op_class = 2'b01;
                        state_d      = StWb;
                    end
                    OpI: begin
                        alu_src_a    = 2'b10;
                        alu_src_b    = 2'b10;
                        alu_op_class = 2'b01;
                        state_d      = StWb;
                    end
                    OpLoad, OpStore: begin
                        alu_src_a = 2'b10;
                        alu_src_b = 2'b10;
                        state_d   = StMem;
                    end
                    OpBranch: begin
                        alu_src_a    = 2'b10;
                        alu_op_class = 2'b10;
                        pc_write     = bcond;
                        pc_source    = 2'b01;
                    end
                    OpJal: begin
                        reg_write = 1'b1;
                        wb_sel    = 2'b10;
                        pc_write  = 1'b1;
                        pc_source = 2'b01;
                    end
                    OpJalr: begin
                        alu_src_a = 2'b10;
                        alu_src_b = 2'b10;
                        reg_write = 1'b1;
                        wb_sel    = 2'b10;
                        pc_write  = 1'b1;
                        pc_source = 2'b10;
                    end
                    default: state_d = StIf;
                endcase
            end
            StMem: begin
                i_or_d = 1'b1;
                if (opcode == OpLoad) begin
                    mem_read = 1'b1;
                    if (mem_ready) state_d = StWb;
                end else if (opcode == OpStore) begin
                    mem_write = 1'b1;
                    if (mem_ready) state_d = StIf;
                end else begin
                    state_d = StIf;
                end
            end
            StWb: begin
                reg_write = 1'b1;
                wb_sel    = (opcode == OpLoad) ? 2'b01 : 2'b00;
                state_d   = StIf;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StIf;
        endcase
    end

    assign is_halted = (state_q == StHalt);
    assign state     = STATE_W'(state_q);

endmodule
